dispatch_queue: RTL and testbench

- Consumer end of the frontend's decode ready/valid output: accepts one `decode_data` per cycle and buffers it in an in-order FIFO.
- Dispatches the head entry to either the ALU issue port or the MEM issue port, selected by the entry's `fu_mem` bit.
- Sits between frontend decode and the issue queues.
- Its `in_ready` is the backpressure the frontend's decode skid buffer sees.

---
 rtl/types_pkg.sv | 22 ++
 rtl/dispatch_fifo.sv | 62 ++++++
 rtl/dispatch_queue.sv | 72 +++++++
 tb/tb_dispatch_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared frontend/dispatch types: the decoded-instruction record and dispatch sizing.
package types_pkg;

    localparam int unsigned DISPATCH_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        fu_alu;
        logic        fu_mem;
    } decode_data;

    // Anything not marked as a memory op, NOP-class included, is routed to the ALU.
    function automatic logic routes_to_mem(input decode_data d);
        return d.fu_mem;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Generic DEPTH x WIDTH in-order FIFO with occupancy count and synchronous flush.
// Storage is unreset; only pointers and count are cleared by reset or flush.
module dispatch_fifo #(
    parameter int unsigned  DEPTH = 8,
    parameter int unsigned  WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage_q[wr_ptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow gives the wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = storage_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/dispatch_queue.sv
// In-order decode-to-issue dispatch queue routing the head entry to the ALU or MEM port.
// Optional same-cycle bypass of an empty queue is enabled by defining DISPATCH_BYPASS_EN.
module dispatch_queue
    import types_pkg::*;
#(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  decode_data       in_data,
    output logic             alu_valid,
    input  logic             alu_ready,
    output decode_data       alu_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output decode_data       mem_data,
    output logic [PTR_W:0]   count
);

    decode_data fifo_rdata;
    decode_data head;
    logic       fifo_full, fifo_empty;
    logic       fifo_push, fifo_pop;
    logic       bypass, out_en, to_mem, fire;

`ifdef DISPATCH_BYPASS_EN
    assign bypass = reset && fifo_empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign head   = bypass ? in_data : fifo_rdata;
    assign to_mem = routes_to_mem(head);

    // reset masks the handshakes so nothing is offered while reset is held.
    assign in_ready  = reset && !fifo_full && !flush;
    assign out_en    = reset && !flush && (!fifo_empty || bypass);
    assign alu_valid = out_en && !to_mem;
    assign mem_valid = out_en && to_mem;
    assign alu_data  = head;
    assign mem_data  = head;

    assign fire = (alu_valid && alu_ready) || (mem_valid && mem_ready);

    // A bypassed instruction that dispatches this cycle never touches storage.
    assign fifo_push = in_valid && in_ready && !(bypass && fire);
    assign fifo_pop  = fire && !bypass;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(decode_data))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    valids_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(alu_valid && mem_valid));

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized self-checking bench for dispatch_queue against a queue-based reference model.
module tb_dispatch_queue;
    import types_pkg::*;

    localparam int unsigned DEPTH = DISPATCH_DEPTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    decode_data     in_data = '0;
    logic           alu_valid, mem_valid;
    logic           alu_ready = 1'b0, mem_ready = 1'b0;
    decode_data     alu_data, mem_data;
    logic [PTR_W:0] count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    decode_data model_q[$];
    logic       exp_alu, exp_mem, exp_byp;
    decode_data exp_head;

    always #5 clk = ~clk;

    dispatch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .count     (count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic decode_data mk(input logic [31:0] pc, input logic alu, input logic mem);
        decode_data d;
        d        = '0;
        d.pc     = pc;
        d.fu_alu = alu;
        d.fu_mem = mem;
        return d;
    endfunction

    function automatic decode_data rnd_data();
        decode_data d;
        d.pc     = $urandom;
        d.imm    = $urandom;
        d.opcode = 7'($urandom);
        d.rd     = 5'($urandom);
        d.rs1    = 5'($urandom);
        d.rs2    = 5'($urandom);
        d.fu_alu = 1'($urandom);
        d.fu_mem = 1'($urandom);
        return d;
    endfunction

    // Expected outputs for the current inputs, derived from the reference queue contents.
    task automatic check_outputs();
        logic emp;
        logic full;
        logic ov;
        emp     = (model_q.size() == 0);
        full    = (model_q.size() == DEPTH);
        exp_byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
        exp_byp = emp && in_valid && !flush;
`endif
        if (exp_byp)   exp_head = in_data;
        else if (!emp) exp_head = model_q[0];
        else           exp_head = '0;
        ov      = !flush && (!emp || exp_byp);
        exp_alu = ov && !exp_head.fu_mem;
        exp_mem = ov && exp_head.fu_mem;
        check("in_ready", in_ready, !full && !flush);
        check("alu_valid", alu_valid, exp_alu);
        check("mem_valid", mem_valid, exp_mem);
        check("count", count, model_q.size());
        if (exp_alu) check("alu_data", alu_data, exp_head);
        if (exp_mem) check("mem_data", mem_data, exp_head);
    endtask

    task automatic model_update();
        logic fire;
        logic accept;
        if (flush) begin
            model_q.delete();
        end else begin
            fire   = (exp_alu && alu_ready) || (exp_mem && mem_ready);
            accept = in_valid && (model_q.size() < DEPTH);
            if (exp_byp) begin
                if (!fire) model_q.push_back(in_data);
            end else begin
                if (fire) void'(model_q.pop_front());
                if (accept) model_q.push_back(in_data);
            end
        end
    endtask

    // Called at a negedge; drives inputs, checks, then advances one clock.
    task automatic cycle(input logic iv, input decode_data d, input logic ar, input logic mr,
                         input logic fl);
        in_valid  = iv;
        in_data   = d;
        alu_ready = ar;
        mem_ready = mr;
        flush     = fl;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ar, input logic mr);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, ar, mr, 1'b0);
    endtask

    initial begin
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_count", count, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Three ALU pushes drained in order.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'(4 * i), 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);

        // Mixed stream with the MEM port stalled: later ALU entry must wait.
        cycle(1'b1, mk(32'h0, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h4, 1'b0, 1'b1), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h8, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);

        // Fill to full with the ALU stalled, offer a 9th, then drain while refilling.
        for (int i = 0; i < 9; i++) cycle(1'b1, mk(32'(16 * i), 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, mk(32'(256 + i), 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
        idle(DEPTH + 2, 1'b1, 1'b1);

        // Flush at count=5 alongside a push and a ready ALU.
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(32'(i), 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk(32'h77, 1'b1, 1'b0), 1'b1, 1'b1, 1'b1);
        cycle(1'b1, mk(32'h80, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a cycle with three entries held.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'(i), 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1'b0);
        check("arst_alu_valid", alu_valid, 1'b0);
        check("arst_mem_valid", mem_valid, 1'b0);
        check("arst_count", count, 0);
        model_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        idle(1, 1'b0, 1'b0);

`ifdef DISPATCH_BYPASS_EN
        cycle(1'b1, mk(32'h10, 1'b0, 1'b1), 1'b0, 1'b1, 1'b0);
        check("bypass_count", count, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 9) < 7), rnd_data(), ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 9) < 5), ($urandom_range(0, 49) == 0));
        end
        idle(DEPTH + 2, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
